// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I field descriptors into words and streams them to instruction memory (optional ENC_CHECK_EN field checking)
module instr_encoder #(
  parameter int ADDR_W = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;
  state_t state;
  logic [ADDR_W-1:0] ptr;
  logic last_q;
  logic [31:0] enc;
  logic bad;
  // pack the descriptor fields for the selected format; illegal formats become a NOP
  always_comb
    enc = in_fmt == 3'd0 ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode} :
          in_fmt == 3'd1 ? {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode} :
          in_fmt == 3'd2 ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode} :
          in_fmt == 3'd3 ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode} :
          in_fmt == 3'd4 ? {in_imm[31:12], in_rd, in_opcode} :
          in_fmt == 3'd5 ? {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode} :
                           32'h0000_0013;
`ifdef ENC_CHECK_EN
  logic fit12, fit13, fit21;
  assign fit12 = &in_imm[31:11] | ~|in_imm[31:11];
  assign fit13 = &in_imm[31:12] | ~|in_imm[31:12];
  assign fit21 = &in_imm[31:20] | ~|in_imm[31:20];
  assign bad = in_fmt > 3'd5 |
               ((in_fmt == 3'd1 | in_fmt == 3'd2) & ~fit12) |
               (in_fmt == 3'd3 & (in_imm[0] | ~fit13)) |
               (in_fmt == 3'd5 & (in_imm[0] | ~fit21)) |
               (in_fmt == 3'd4 & |in_imm[11:0]);
`else
  assign bad = 1'b0;
`endif
  // session FSM with registered handshake and status outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      last_q <= 1'b0;
      in_ready <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      count <= '0;
      err <= 1'b0;
    end else
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= ACCEPT;
            ptr <= ADDR_W'(BASE_ADDR);
            count <= '0;
            err <= 1'b0;
            in_ready <= 1'b1;
            busy <= 1'b1;
            done <= 1'b0;
          end
        ACCEPT:
          if (in_valid)
            if (bad) begin
              err <= 1'b1;
              if (in_last) begin
                state <= DONE;
                in_ready <= 1'b0;
                busy <= 1'b0;
                done <= 1'b1;
              end
            end else begin
              state <= WRITE;
              wr_data <= enc;
              wr_addr <= ptr;
              last_q <= in_last;
              in_ready <= 1'b0;
              wr_en <= 1'b1;
            end
        default:
          if (wr_ready) begin
            wr_en <= 1'b0;
            ptr <= ptr + 1'b1;
            count <= count + 1'b1;
            if (last_q || ptr == LAST_PTR) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              state <= ACCEPT;
              in_ready <= 1'b1;
            end
          end
      endcase
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of packing, handshakes, address limit and reset for instr_encoder
module tb_instr_encoder;
  logic clk = 0, rst_d = 1, rst_s = 1, sel = 0;
  logic start = 0, in_valid = 0, in_last = 0, wr_ready = 1;
  logic [2:0] in_fmt = 0, in_funct3 = 0;
  logic [6:0] in_opcode = 0, in_funct7 = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [31:0] in_imm = 0;
  logic ir_d, we_d, busy_d, done_d, err_d;
  logic [9:0] wa_d;
  logic [31:0] wd_d;
  logic [10:0] cnt_d;
  logic ir_s, we_s, busy_s, done_s, err_s;
  logic [1:0] wa_s;
  logic [31:0] wd_s;
  logic [2:0] cnt_s;
  logic o_ir, o_we, o_busy, o_done, o_err;
  logic [31:0] o_wa, o_wd, o_cnt;
  int n = 0, fails = 0;

  always #5 clk = ~clk;

  instr_encoder dut (.clk(clk), .rst(rst_d), .start(start), .in_valid(in_valid), .in_ready(ir_d),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .wr_en(we_d), .wr_addr(wa_d), .wr_data(wd_d), .wr_ready(wr_ready), .busy(busy_d),
    .done(done_d), .count(cnt_d), .err(err_d));

  instr_encoder #(.ADDR_W(2)) dut_s (.clk(clk), .rst(rst_s), .start(start), .in_valid(in_valid), .in_ready(ir_s),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .wr_en(we_s), .wr_addr(wa_s), .wr_data(wd_s), .wr_ready(wr_ready), .busy(busy_s),
    .done(done_s), .count(cnt_s), .err(err_s));

  assign o_ir = sel ? ir_s : ir_d;
  assign o_we = sel ? we_s : we_d;
  assign o_busy = sel ? busy_s : busy_d;
  assign o_done = sel ? done_s : done_d;
  assign o_err = sel ? err_s : err_d;
  assign o_wa = sel ? 32'(wa_s) : 32'(wa_d);
  assign o_wd = sel ? wd_s : wd_d;
  assign o_cnt = sel ? 32'(cnt_s) : 32'(cnt_d);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"}, 32'(o_we), 0);
    chk({tag, "_wa"}, o_wa, 0);
    chk({tag, "_wd"}, o_wd, 0);
    chk({tag, "_ir"}, 32'(o_ir), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_cnt"}, o_cnt, 0);
    chk({tag, "_err"}, 32'(o_err), 0);
  endtask

  task automatic send(input string tag, input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic last);
    logic ok = 0;
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last; in_valid = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (o_ir) ok = 1;
      tick();
    end
    in_valid = 0;
    chk({tag, "_hs"}, 32'(ok), 1);
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_we"}, 32'(o_we), 1);
    chk({tag, "_wa"}, o_wa, addr);
    chk({tag, "_wd"}, o_wd, data);
    chk({tag, "_ir"}, 32'(o_ir), 0);
  endtask

  initial begin
    tick();
    chk_reset("rst");
    rst_d = 0;
    tick();
    pulse_start();
    chk("start_ir", 32'(o_ir), 1);
    chk("start_busy", 32'(o_busy), 1);
    send("add", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1);
    chk_wr("add", 0, 32'h002081B3);
    tick();
    chk("add_done", 32'(o_done), 1);
    chk("add_cnt", o_cnt, 1);
    chk("add_busy", 32'(o_busy), 0);
    chk("add_we_off", 32'(o_we), 0);
    pulse_start();
    chk("s2_done", 32'(o_done), 0);
    chk("s2_cnt", o_cnt, 0);
    send("addi", 3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 0);
    chk_wr("addi", 0, 32'hFFF00293);
    tick();
    chk("addi_ir", 32'(o_ir), 1);
    send("beq", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 0);
    chk_wr("beq", 1, 32'hFE208EE3);
    tick();
    chk("beq_cnt", o_cnt, 2);
    send("jal", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 0);
    chk_wr("jal", 2, 32'h008000EF);
    tick();
    wr_ready = 0;
    send("lui", 3'd4, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 0);
    chk_wr("lui", 3, 32'h12345137);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_wr("hold", 3, 32'h12345137);
      chk("hold_cnt", o_cnt, 3);
    end
    wr_ready = 1;
    tick();
    chk("lui_cnt", o_cnt, 4);
    chk("lui_ir", 32'(o_ir), 1);
`ifdef ENC_CHECK_EN
    send("bad_b", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 0);
    chk("bad_b_err", 32'(o_err), 1);
    chk("bad_b_we", 32'(o_we), 0);
    chk("bad_b_ir", 32'(o_ir), 1);
    chk("bad_b_cnt", o_cnt, 4);
    send("bad_fmt", 3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1);
    chk("bad_fmt_done", 32'(o_done), 1);
    chk("bad_fmt_cnt", o_cnt, 4);
    chk("bad_fmt_err", 32'(o_err), 1);
`else
    send("nop", 3'd7, 7'h55, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFFFFFF, 1);
    chk_wr("nop", 4, 32'h00000013);
    tick();
    chk("nop_done", 32'(o_done), 1);
    chk("nop_cnt", o_cnt, 5);
    chk("nop_err", 32'(o_err), 0);
`endif
    rst_d = 1;
    sel = 1;
    tick();
    chk_reset("s_rst");
    rst_s = 0;
    tick();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send("lim", 3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 0);
      chk_wr("lim", 32'(i), {12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13});
      tick();
    end
    chk("lim_done", 32'(o_done), 1);
    chk("lim_cnt", o_cnt, 4);
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lim5_ir", 32'(o_ir), 0);
      chk("lim5_we", 32'(o_we), 0);
    end
    in_valid = 0;
    chk("lim5_cnt", o_cnt, 4);
    pulse_start();
    send("r1", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 0);
    tick();
    wr_ready = 0;
    send("r2", 3'd0, 7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 0);
    chk_wr("r2", 1, 32'h00208233);
    rst_s = 1;
    #1;
    chk("async_we", 32'(o_we), 0);
    tick();
    chk_reset("mid_rst");
    wr_ready = 1;
    rst_s = 0;
    tick();
    chk("idle_ir", 32'(o_ir), 0);
    chk("idle_busy", 32'(o_busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
